// File: rtl/pipe_cla_pkg.sv
// pipe_cla_pkg
// Shared types and elaboration helpers for the pipelined CLA adder-subtractor.
//   addsub_flags_t : status flags produced alongside each result
//   calc_stages()  : pipeline depth for a WIDTH/SLICE split; 0 flags a bad split
package pipe_cla_pkg;

  typedef struct packed {
    logic cout;   // raw carry out of the MSB (for subtract, 1 = no borrow)
    logic v;      // signed overflow
    logic zero;   // result == 0
    logic neg;    // result MSB
  } addsub_flags_t;

  localparam int DEFAULT_WIDTH = 32'sd16;
  localparam int DEFAULT_SLICE = 32'sd4;

  // Number of slices/stages; returns 0 when WIDTH is not a positive multiple
  // of SLICE so the instantiating module can stop elaboration.
  function automatic int calc_stages(input int width, input int slice);
    if ((slice <= 32'sd0) || (width <= 32'sd0) || ((width % slice) != 32'sd0)) begin
      return 32'sd0;
    end else begin
      return width / slice;
    end
  endfunction

endpackage

// File: rtl/cla_slice.sv
// cla_slice
// Combinational SLICE-bit carry look-ahead adder slice.
// Ports:
//   a, b   : slice operands (b already inverted by the caller for subtract)
//   c_in   : carry into bit 0 of the slice
//   sum    : slice sum bits
//   c_out  : carry out of the slice MSB
//   c_msb  : carry into the slice MSB (used for signed overflow)
//   g, p   : group generate / propagate of the whole slice
module cla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c_in,
  output logic [SLICE-1:0] sum,
  output logic             c_out,
  output logic             c_msb,
  output logic             g,
  output logic             p
);

  logic [SLICE-1:0] pb_s;
  logic [SLICE-1:0] gb_s;
  logic [SLICE:0]   c_s;

  // AND of pv[lo .. hi-1]; an empty span is 1 (propagates trivially).
  function automatic logic span_and(input logic [SLICE-1:0] pv, input int lo, input int hi);
    logic r;
    r = 1'b1;
    for (int i = 0; i < SLICE; i++) begin
      if ((i >= lo) && (i < hi)) begin
        r = r & pv[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign pb_s = a ^ b;
  assign gb_s = a & b;

  // Look-ahead carries: each carry is a flat sum of products of generate
  // terms and propagate spans, so no carry depends on a lower carry.
  always_comb begin
    c_s = '0;
    g   = 1'b0;
    for (int i = 0; i <= SLICE; i++) begin
      c_s[i] = c_in & span_and(pb_s, 32'sd0, i);
      for (int j = 0; j < SLICE; j++) begin
        if (j < i) begin
          c_s[i] = c_s[i] | (gb_s[j] & span_and(pb_s, j + 32'sd1, i));
        end else begin
          c_s[i] = c_s[i];
        end
      end
    end
    for (int j = 0; j < SLICE; j++) begin
      g = g | (gb_s[j] & span_and(pb_s, j + 32'sd1, SLICE));
    end
  end

  assign p     = &pb_s;
  assign sum   = pb_s ^ c_s[SLICE-1:0];
  assign c_out = c_s[SLICE];
  assign c_msb = c_s[SLICE-1];

endmodule

// File: rtl/pipe_cla_addsub.sv
// pipe_cla_addsub
// Pipelined carry look-ahead adder-subtractor, one SLICE-bit slice per stage.
// result = x + (sub ? ~y : y) + (sub | cin), latency STAGES, 1 op/cycle.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready = pipeline may advance)
//   sub, cin, x, y      : operation select, carry-in (ignored for sub), operands
//   out_valid/out_ready : output handshake with full backpressure
//   result              : sum or difference
//   cout, v, zero, neg  : raw carry out, signed overflow, zero, sign
module pipe_cla_addsub
  import pipe_cla_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             v,
  output logic             zero,
  output logic             neg
);

  localparam int STAGES = calc_stages(WIDTH, SLICE);

  if (STAGES == 32'sd0) begin : g_bad_cfg
    $error("pipe_cla_addsub: WIDTH must be a positive multiple of SLICE");
  end

  logic             adv_s;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  addsub_flags_t    flags_q, flags_d;
  logic [WIDTH-1:0] last_res_s;
  logic             last_vld_s;
  logic             last_cout_s;
  logic             last_cmsb_s;

  // The whole pipeline moves as one unit; it only freezes while a result
  // is waiting at the output and the consumer is not taking it.
  assign adv_s    = (!out_valid_q) || out_ready;
  assign in_ready = adv_s;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added shrink by one slice per stage while
    // the finished result bits grow by one slice.
    localparam int OPW  = WIDTH - (k * SLICE);
    localparam int RESW = (k + 1) * SLICE;

    logic             vld_q, vld_d;
    logic             c_q, c_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic [SLICE-1:0] sum_s;
    logic             c_out_s;
    logic             c_msb_s;
    logic             g_s;
    logic             p_s;
    logic [RESW-1:0]  res_s;

    cla_slice #(.SLICE(SLICE)) u_slice (
      .a     (a_q[SLICE-1:0]),
      .b     (b_q[SLICE-1:0]),
      .c_in  (c_q),
      .sum   (sum_s),
      .c_out (c_out_s),
      .c_msb (c_msb_s),
      .g     (g_s),
      .p     (p_s)
    );

    if (k == 0) begin : g_first
      // Stage 0 takes the ports directly; subtract becomes x + ~y + 1 here.
      always_comb begin
        if (adv_s) begin
          vld_d = in_valid;
          c_d   = sub | cin;
          a_d   = x;
          b_d   = sub ? ~y : y;
        end else begin
          vld_d = vld_q;
          c_d   = c_q;
          a_d   = a_q;
          b_d   = b_q;
        end
      end

      assign res_s = sum_s;
    end else begin : g_next
      logic [(k*SLICE)-1:0] res_q, res_d;

      // Later stages take the previous slice's carry, the unconsumed operand
      // bits and the result bits completed so far.
      always_comb begin
        if (adv_s) begin
          vld_d = g_stage[k-1].vld_q;
          c_d   = g_stage[k-1].c_out_s;
          a_d   = g_stage[k-1].a_q[OPW+SLICE-1:SLICE];
          b_d   = g_stage[k-1].b_q[OPW+SLICE-1:SLICE];
          res_d = g_stage[k-1].res_s;
        end else begin
          vld_d = vld_q;
          c_d   = c_q;
          a_d   = a_q;
          b_d   = b_q;
          res_d = res_q;
        end
      end

      // Output-deskew register for the lower result bits.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_q <= '0;
        end else begin
          res_q <= res_d;
        end
      end

      assign res_s = {sum_s, res_q};
    end

    // Stage valid, carry and input-skew operand registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        a_q   <= '0;
        b_q   <= '0;
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        a_q   <= a_d;
        b_q   <= b_d;
      end
    end
  end

  assign last_res_s  = g_stage[STAGES-1].res_s;
  assign last_vld_s  = g_stage[STAGES-1].vld_q;
  assign last_cout_s = g_stage[STAGES-1].c_out_s;
  assign last_cmsb_s = g_stage[STAGES-1].c_msb_s;

  // Output stage: completed word plus flags from the top slice's carries.
  always_comb begin
    if (adv_s) begin
      out_valid_d  = last_vld_s;
      result_d     = last_res_s;
      flags_d.cout = last_cout_s;
      flags_d.v    = last_cmsb_s ^ last_cout_s;
      flags_d.zero = (last_res_s == '0);
      flags_d.neg  = last_res_s[WIDTH-1];
    end else begin
      out_valid_d  = out_valid_q;
      result_d     = result_q;
      flags_d      = flags_q;
    end
  end

  // Output registers; held stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = flags_q.cout;
  assign v         = flags_q.v;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// tb_pipe_cla_addsub
// Self-checking bench for pipe_cla_addsub (WIDTH=16, SLICE=4).
// Expected results come from signed/unsigned integer arithmetic; a queue
// holds expectations in issue order.
module tb_pipe_cla_addsub;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int STAGES = 4;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;   // {cout, v, zero, neg}
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sub;
  logic        cin;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        v;
  logic        zero;
  logic        neg;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_retired = 0;
  bit          lat_check = 1'b1;
  bit          hold_pending = 1'b0;
  logic [15:0] hold_res;
  logic [3:0]  hold_flags;
  bit          got_out = 1'b0;
  logic [15:0] last_res;
  logic [3:0]  last_flags;
  exp_t        sb[$];

  pipe_cla_addsub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .cin       (cin),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .v         (v),
    .zero      (zero),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ideal signed/unsigned results, reduced modulo 2^16.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic ci, input int c);
    exp_t e;
    int   sa, sb_i, ua, ub, us, ideal;
    logic co, ov;
    sa = $signed(a);
    sb_i = $signed(b);
    ua = a;
    ub = b;
    if (s) begin
      ideal = sa - sb_i;
      us    = ua - ub;
      co    = (ua >= ub);
    end else begin
      ideal = sa + sb_i + ci;
      us    = ua + ub + ci;
      co    = (us > 65535);
    end
    ov      = (ideal > 32767) || (ideal < -32768);
    e.res   = us[15:0];
    e.flags = {co, ov, (e.res == 16'h0000), e.res[15]};
    e.cyc   = c;
    return e;
  endfunction

  // One clock: drive after the falling edge, then check outputs and the
  // handshake before the next rising edge.
  task automatic cycle(input logic iv, input logic isub, input logic icin,
                       input logic [15:0] ix, input logic [15:0] iy,
                       input logic ordy, output logic accepted);
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    sub       = isub;
    cin       = icin;
    x         = ix;
    y         = iy;
    out_ready = ordy;
    #1;
    cyc++;
    if (hold_pending) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'(hold_res));
      chk("hold_flags", 32'({cout, v, zero, neg}), 32'(hold_flags));
      hold_pending = 1'b0;
    end
    chk("in_ready_rule", 32'(in_ready), 32'((!out_valid) || ordy));
    if (out_valid) begin
      if (!ordy) begin
        hold_pending = 1'b1;
        hold_res     = result;
        hold_flags   = {cout, v, zero, neg};
      end else if (sb.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        n_retired++;
        got_out    = 1'b1;
        last_res   = result;
        last_flags = {cout, v, zero, neg};
        chk("result", 32'(result), 32'(e.res));
        chk("flags", 32'({cout, v, zero, neg}), 32'(e.flags));
        // accepted at the rising edge ending call N, first seen in call N+STAGES+1
        if (lat_check) chk("latency", 32'(cyc - e.cyc), 32'(STAGES + 1));
      end
    end
    accepted = iv && in_ready;
    if (accepted) sb.push_back(model(ix, iy, isub, icin, cyc));
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, acc);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && (n < 20)) begin
      cycle(1'b1, s, ci, a, b, 1'b1, acc);
      n++;
    end
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((sb.size() != 0) && (n < max)) begin
      idle(1);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Directed op checked against the values worked out by hand.
  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic ci,
                        input logic [15:0] er, input logic [3:0] ef);
    int n;
    got_out = 1'b0;
    send(a, b, s, ci);
    n = 0;
    while (!got_out && (n < 12)) begin
      idle(1);
      n++;
    end
    chk({tag, "_seen"}, 32'(got_out), 32'd1);
    chk({tag, "_res"}, 32'(last_res), 32'(er));
    chk({tag, "_flags"}, 32'(last_flags), 32'(ef));
  endtask

  initial begin
    logic [15:0] bx[6];
    logic [15:0] by[6];
    logic        bs[6];
    logic        acc;
    int          idx;
    int          blocked;
    int          base_ret;

    rst       = 1'b1;
    in_valid  = 1'b0;
    sub       = 1'b0;
    cin       = 1'b0;
    x         = 16'h0000;
    y         = 16'h0000;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({cout, v, zero, neg}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic and boundary values ({cout, v, zero, neg})
    single("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 4'b0000);
    single("sub_0m1",   16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 4'b0001);
    single("sub_cin",   16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 4'b1000);
    single("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0101);
    single("wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1010);
    single("sub_zero",  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b1010);
    single("ovf_neg",   16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 4'b1100);
    single("add_cin",   16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 4'b1010);

    // Random back-to-back stream, one result per cycle
    base_ret = n_retired;
    for (int i = 0; i < 200; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    drain(20);
    chk("stream_count", 32'(n_retired - base_ret), 32'd200);

    // Backpressure: stall the consumer for 3 cycles mid-stream
    lat_check = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bx[i] = 16'($urandom);
      by[i] = 16'($urandom);
      bs[i] = 1'($urandom);
    end
    idx      = 0;
    blocked  = 0;
    base_ret = n_retired;
    for (int t = 0; (t < 40) && ((idx < 6) || (sb.size() != 0)); t++) begin
      logic ordy;
      ordy = !((t >= 5) && (t < 8));
      if (idx < 6) cycle(1'b1, bs[idx], 1'b0, bx[idx], by[idx], ordy, acc);
      else         cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, ordy, acc);
      if (acc) idx++;
      if (!ordy && !in_ready) blocked++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd6);
    chk("bp_in_ready_low", 32'(blocked), 32'd3);
    chk("bp_delivered", 32'(n_retired - base_ret), 32'd6);
    lat_check = 1'b1;
    idle(2);

    // Asynchronous reset with ops in flight
    for (int t = 0; t < 6; t++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0100 + 16'(t), 16'h0011, 1'b1, acc);
    end
    #2;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_flags", 32'({cout, v, zero, neg}), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    hold_pending = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_held_in_ready", 32'(in_ready), 32'd1);
    chk("rst_held_valid", 32'(out_valid), 32'd0);
    #2;
    rst = 1'b0;
    idle(8);
    single("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 4'b0000);
    drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
